bp_be_prefetch_stream_engine: RTL and testbench

Multi-stream successor to the single-stream stride prefetch generator. It holds up to streams_p independent strided-load streams, keyed by load PC. Each stream walks its address sequence by a signed stride and raises one prefetch per new D$ block touched. A round-robin arbiter selects among ready streams and presents one prefetch request per cycle to the BE dispatch-packet former, which issues it as a prefetch.r.

---
 rtl/bp_be_prefetch_stream_engine.sv | 194 +++++++++++++++++++
 tb/tb_bp_be_prefetch_stream_engine.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_prefetch_stream_engine.sv
// Multi-stream strided prefetcher: PC-keyed slots walk by a signed stride and raise one request per new D$ block.
// Allocation-to-request latency is at least 2 cycles; a slot stalls in SEND, with its request held stable, until yumi_i.
module bp_be_prefetch_stream_engine
  #(parameter int vaddr_width_p        = 39
   ,parameter int dcache_block_width_p = 512
   ,parameter int streams_p            = 4
   ,parameter int loop_range_p         = 8
   ,parameter int stride_width_p       = 12
   ,localparam int lg_streams_lp   = (streams_p > 1) ? $clog2(streams_p) : 1
   ,localparam int block_offset_lp = (dcache_block_width_p > 15) ? $clog2(dcache_block_width_p/8) : 1
   ,localparam int blk_width_lp    = vaddr_width_p - block_offset_lp
   )
  (input  logic                      clk_i
  ,input  logic                      reset_i
  ,input  logic [vaddr_width_p-1:0]  pc_i
  ,input  logic [vaddr_width_p-1:0]  eff_addr_i
  ,input  logic [stride_width_p-1:0] stride_i
  ,input  logic [loop_range_p-1:0]   loop_counter_i
  ,input  logic                      v_i
  ,output logic                      ready_and_o
  ,input  logic                      flush_i
  ,output logic                      v_o
  ,output logic [vaddr_width_p-1:0]  pf_vaddr_o
  ,output logic [vaddr_width_p-1:0]  pf_pc_o
  ,output logic [lg_streams_lp-1:0]  pf_slot_o
  ,input  logic                      yumi_i
  );

   typedef enum logic [1:0] {e_idle = 2'd0, e_walk = 2'd1, e_send = 2'd2} state_e;

   state_e                    state_r  [streams_p];
   state_e                    state_n  [streams_p];
   logic [vaddr_width_p-1:0]  pc_r     [streams_p];
   logic [vaddr_width_p-1:0]  pc_n     [streams_p];
   logic [vaddr_width_p-1:0]  addr_r   [streams_p];
   logic [vaddr_width_p-1:0]  addr_n   [streams_p];
   logic [vaddr_width_p-1:0]  stride_r [streams_p];
   logic [vaddr_width_p-1:0]  stride_n [streams_p];
   logic [loop_range_p-1:0]   count_r  [streams_p];
   logic [loop_range_p-1:0]   count_n  [streams_p];
   logic [blk_width_lp-1:0]   blk_r    [streams_p];
   logic [blk_width_lp-1:0]   blk_n    [streams_p];

   logic [lg_streams_lp-1:0]  rr_r, rr_next;
   logic                      lock_v_r;
   logic [lg_streams_lp-1:0]  lock_idx_r;

   logic                      any_idle, match_v, alloc;
   logic [lg_streams_lp-1:0]  idle_idx, match_idx, alloc_idx;
   logic [vaddr_width_p-1:0]  stride_sext;

   logic                      any_send, hi_v;
   logic [lg_streams_lp-1:0]  hi_idx, lo_idx, search_idx, grant_idx;
   logic                      lock_hit;

   logic [vaddr_width_p-1:0]  step_addr;
   logic [loop_range_p-1:0]   step_count;

   assign stride_sext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};

   // Stream lookup: live slots never share a pc, so at most one match exists.
   always_comb begin
      any_idle  = 1'b0;
      match_v   = 1'b0;
      idle_idx  = '0;
      match_idx = '0;
      for (int s = streams_p-1; s >= 0; s--) begin
         if (state_r[s] == e_idle) begin
            any_idle = 1'b1;
            idle_idx = lg_streams_lp'(s);
         end
         else if (pc_r[s] == pc_i) begin
            match_v   = 1'b1;
            match_idx = lg_streams_lp'(s);
         end
      end
   end

   assign ready_and_o = any_idle | match_v;
   assign alloc       = v_i & ready_and_o & ~flush_i;
   assign alloc_idx   = match_v ? match_idx : idle_idx;

   // Cyclic search from rr_r: lowest SEND at/after the pointer, else lowest SEND overall.
   always_comb begin
      any_send = 1'b0;
      hi_v     = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int s = streams_p-1; s >= 0; s--) begin
         if (state_r[s] == e_send) begin
            any_send = 1'b1;
            lo_idx   = lg_streams_lp'(s);
            if (lg_streams_lp'(s) >= rr_r) begin
               hi_v   = 1'b1;
               hi_idx = lg_streams_lp'(s);
            end
         end
      end
   end

   assign search_idx = hi_v ? hi_idx : lo_idx;
   // A request already presented but not taken keeps the grant, so the outputs stay stable.
   assign lock_hit   = lock_v_r & (state_r[lock_idx_r] == e_send);
   assign grant_idx  = lock_hit ? lock_idx_r : search_idx;
   assign rr_next    = (grant_idx == lg_streams_lp'(streams_p-1))
                       ? '0 : grant_idx + lg_streams_lp'(1);

   assign v_o        = any_send;
   assign pf_vaddr_o = v_o ? {blk_r[grant_idx], {block_offset_lp{1'b0}}} : '0;
   assign pf_pc_o    = v_o ? pc_r[grant_idx] : '0;
   assign pf_slot_o  = v_o ? grant_idx : '0;

   always_comb begin
      step_addr  = '0;
      step_count = '0;
      for (int s = 0; s < streams_p; s++) begin
         state_n[s]  = state_r[s];
         pc_n[s]     = pc_r[s];
         addr_n[s]   = addr_r[s];
         stride_n[s] = stride_r[s];
         count_n[s]  = count_r[s];
         blk_n[s]    = blk_r[s];

         step_addr  = addr_r[s] + stride_r[s];
         step_count = count_r[s] - loop_range_p'(1);

         case (state_r[s])
            e_walk: begin
               addr_n[s]  = step_addr;
               count_n[s] = step_count;
               if (step_addr[vaddr_width_p-1:block_offset_lp] != blk_r[s]) begin
                  blk_n[s]   = step_addr[vaddr_width_p-1:block_offset_lp];
                  state_n[s] = e_send;
               end
               else if (step_count == '0) begin
                  state_n[s] = e_idle;
               end
            end
            e_send: begin
               if (yumi_i && (grant_idx == lg_streams_lp'(s)))
                  state_n[s] = (count_r[s] == '0) ? e_idle : e_walk;
            end
            default: ;
         endcase

         // A new allocation overrides whatever the slot was doing, including a taken request.
         if (alloc && (alloc_idx == lg_streams_lp'(s))) begin
            pc_n[s]     = pc_i;
            addr_n[s]   = eff_addr_i;
            stride_n[s] = stride_sext;
            count_n[s]  = loop_counter_i;
            blk_n[s]    = eff_addr_i[vaddr_width_p-1:block_offset_lp];
            state_n[s]  = ((loop_counter_i == '0) || (stride_i == '0)) ? e_idle : e_walk;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_r       <= '0;
         lock_v_r   <= 1'b0;
         lock_idx_r <= '0;
         for (int s = 0; s < streams_p; s++) begin
            state_r[s]  <= e_idle;
            pc_r[s]     <= '0;
            addr_r[s]   <= '0;
            stride_r[s] <= '0;
            count_r[s]  <= '0;
            blk_r[s]    <= '0;
         end
      end
      else if (flush_i) begin
         rr_r     <= '0;
         lock_v_r <= 1'b0;
         for (int s = 0; s < streams_p; s++)
            state_r[s] <= e_idle;
      end
      else begin
         if (yumi_i)
            rr_r <= rr_next;
         lock_v_r   <= v_o & ~yumi_i;
         lock_idx_r <= grant_idx;
         for (int s = 0; s < streams_p; s++) begin
            state_r[s]  <= state_n[s];
            pc_r[s]     <= pc_n[s];
            addr_r[s]   <= addr_n[s];
            stride_r[s] <= stride_n[s];
            count_r[s]  <= count_n[s];
            blk_r[s]    <= blk_n[s];
         end
      end
   end

endmodule

// File: tb/tb_bp_be_prefetch_stream_engine.sv
// Bench for bp_be_prefetch_stream_engine: directed scenarios plus a random phase scored per stream PC.
module tb_bp_be_prefetch_stream_engine;
   localparam int V  = 39;
   localparam int NS = 4;
   localparam int LR = 8;
   localparam int SW = 12;

   logic          clk = 1'b0;
   logic          reset_i, v_i, flush_i, yumi_i;
   logic          ready_and_o, v_o;
   logic [V-1:0]  pc_i, eff_addr_i, pf_vaddr_o, pf_pc_o;
   logic [SW-1:0] stride_i;
   logic [LR-1:0] loop_counter_i;
   logic [1:0]    pf_slot_o;

   always #5 clk = ~clk;

   bp_be_prefetch_stream_engine #(
      .vaddr_width_p(V), .dcache_block_width_p(512), .streams_p(NS),
      .loop_range_p(LR), .stride_width_p(SW)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .pc_i(pc_i), .eff_addr_i(eff_addr_i),
      .stride_i(stride_i), .loop_counter_i(loop_counter_i), .v_i(v_i),
      .ready_and_o(ready_and_o), .flush_i(flush_i), .v_o(v_o),
      .pf_vaddr_o(pf_vaddr_o), .pf_pc_o(pf_pc_o), .pf_slot_o(pf_slot_o), .yumi_i(yumi_i)
   );

   int passes = 0;
   int checks = 0;
   int fails  = 0;

   // Reference: per stream PC, the ordered list of block addresses it still owes.
   bit          m_used [8];
   logic [63:0] m_pc   [8];
   logic [63:0] m_q    [8][$];
   int          grants [$];
   logic [63:0] taken  [$];
   bit          exp_accept;
   bit          hold_v;
   logic [V-1:0] hold_addr, hold_pc;
   logic [1:0]   hold_slot;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int find(input logic [63:0] pc);
      for (int i = 0; i < 8; i++)
         if (m_used[i] && m_pc[i] == pc) return i;
      return -1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_used[i] = 1'b0;
         m_q[i].delete();
      end
   endtask

   task automatic model_alloc(input logic [63:0] pc, input logic [63:0] eff,
                              input logic [SW-1:0] st, input int n);
      int idx;
      logic [63:0] a, s, mask, blk;
      idx = find(pc);
      if (idx < 0)
         for (int i = 7; i >= 0; i--)
            if (!m_used[i] || m_q[i].size() == 0) idx = i;
      m_used[idx] = 1'b1;
      m_pc[idx]   = pc;
      m_q[idx].delete();
      if (st == '0) return;
      mask = (64'd1 << V) - 64'd1;
      s    = {{(64-SW){st[SW-1]}}, st};
      a    = eff;
      blk  = a >> 6;
      for (int k = 0; k < n; k++) begin
         a = (a + s) & mask;
         if ((a >> 6) != blk) begin
            m_q[idx].push_back(a & ~64'h3F);
            blk = a >> 6;
         end
      end
   endtask

   function automatic bit model_empty();
      for (int i = 0; i < 8; i++)
         if (m_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: inputs are already driven; score the cycle, then advance.
   task automatic tick();
      int idx;
      #1;
      if (hold_v) begin
         check("hold_v", v_o, 1'b1);
         check("hold_vaddr", pf_vaddr_o, hold_addr);
         check("hold_pc", pf_pc_o, hold_pc);
         check("hold_slot", pf_slot_o, hold_slot);
      end
      if (v_i) check("ready", ready_and_o, exp_accept);
      if (v_o && yumi_i) begin
         grants.push_back(int'(pf_slot_o));
         taken.push_back(64'(pf_vaddr_o));
         idx = find(64'(pf_pc_o));
         check("pf_owed", (idx >= 0) && (m_q[idx].size() > 0), 1'b1);
         if (idx >= 0 && m_q[idx].size() > 0)
            check("pf_vaddr", pf_vaddr_o, m_q[idx].pop_front());
      end
      hold_v    = v_o && !yumi_i && !flush_i && !(v_i && exp_accept && pc_i == pf_pc_o);
      hold_addr = pf_vaddr_o;
      hold_pc   = pf_pc_o;
      hold_slot = pf_slot_o;
      if (flush_i) model_clear();
      else if (v_i && exp_accept)
         model_alloc(64'(pc_i), 64'(eff_addr_i), stride_i, int'(loop_counter_i));
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic [V-1:0] pc, input logic [V-1:0] eff,
                        input logic [SW-1:0] st, input logic [LR-1:0] n);
      v_i = 1'b1; pc_i = pc; eff_addr_i = eff; stride_i = st; loop_counter_i = n;
      yumi_i = 1'b0;
      tick();
      v_i = 1'b0;
   endtask

   task automatic drain(input int budget);
      v_i = 1'b0; flush_i = 1'b0;
      for (int c = 0; c < budget; c++) begin
         yumi_i = v_o;
         tick();
      end
      yumi_i = 1'b0;
      check("drain_empty", model_empty(), 1'b1);
      check("drain_v_o", v_o, 1'b0);
   endtask

   task automatic do_flush();
      v_i = 1'b0; yumi_i = 1'b0; flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1; v_i = 1'b0; flush_i = 1'b0; yumi_i = 1'b0;
      pc_i = '0; eff_addr_i = '0; stride_i = '0; loop_counter_i = '0;
      exp_accept = 1'b1; hold_v = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      #1;
      check("rst_ready", ready_and_o, 1'b1);
      check("rst_v_o", v_o, 1'b0);
      check("rst_vaddr", pf_vaddr_o, '0);
      check("rst_pc", pf_pc_o, '0);
      check("rst_slot", pf_slot_o, '0);

      // Single stream, stride 8 over 20 steps: two block crossings.
      taken.delete();
      alloc(39'h100, 39'h1000, 12'd8, 8'd20);
      for (int c = 0; c < 30; c++) begin
         check("ss_ready", ready_and_o, 1'b1);
         yumi_i = v_o;
         tick();
      end
      yumi_i = 1'b0;
      check("ss_count", taken.size(), 2);
      if (taken.size() == 2) begin
         check("ss_first", taken[0], 64'h1040);
         check("ss_second", taken[1], 64'h1080);
      end
      check("ss_idle_v", v_o, 1'b0);

      // Negative stride walks downward one block per step.
      taken.delete();
      alloc(39'h180, 39'h2000, 12'hFC0, 8'd3);
      drain(12);
      check("neg_count", taken.size(), 3);
      if (taken.size() == 3) begin
         check("neg_0", taken[0], 64'h1FC0);
         check("neg_1", taken[1], 64'h1F80);
         check("neg_2", taken[2], 64'h1F40);
      end

      // Fairness: four block-per-step streams, yumi every other cycle.
      do_flush();
      grants.delete();
      for (int k = 0; k < 4; k++)
         alloc(39'h200 + 39'(k * 16), 39'h10000 + 39'(k * 39'h1000), 12'd64, 8'd8);
      for (int c = 0; c < 200 && grants.size() < 32; c++) begin
         yumi_i = v_o && (c % 2 == 0);
         tick();
      end
      yumi_i = 1'b0;
      check("fair_count", grants.size(), 32);
      for (int n = 0; n < grants.size(); n++)
         check("fair_slot", grants[n], n % 4);
      drain(20);

      // Full table rejects a new pc; a matching pc replaces slot 2 and drops its pending request.
      for (int k = 0; k < 4; k++)
         alloc(39'h200 + 39'(k * 16), 39'h4000 + 39'(k * 39'h1000), 12'd64, 8'd8);
      for (int c = 0; c < 10; c++) tick();
      exp_accept = 1'b0;
      alloc(39'h999, 39'h8000, 12'd64, 8'd4);
      exp_accept = 1'b1;
      alloc(39'h220, 39'h9000, 12'd64, 8'd2);
      drain(120);

      // Backpressure for 10 cycles, then flush alongside an allocation.
      alloc(39'h240, 39'hA000, 12'd64, 8'd4);
      for (int c = 0; c < 10; c++) tick();
      check("bp_vaddr", pf_vaddr_o, 64'hA040);
      v_i = 1'b1; pc_i = 39'h300; eff_addr_i = 39'hB000; stride_i = 12'd64; loop_counter_i = 8'd5;
      flush_i = 1'b1; yumi_i = v_o;
      tick();
      v_i = 1'b0; flush_i = 1'b0; yumi_i = 1'b0;
      for (int c = 0; c < 6; c++) begin
         check("flush_v_o", v_o, 1'b0);
         tick();
      end
      for (int k = 0; k < 4; k++)
         alloc(39'h400 + 39'(k * 16), 39'hC000, 12'd64, 8'd1);
      exp_accept = 1'b0;
      alloc(39'h480, 39'hD000, 12'd64, 8'd1);
      exp_accept = 1'b1;
      drain(30);

      // Degenerate streams never request; an address wrap lands on block 0.
      do_flush();
      alloc(39'h700, 39'h3000, 12'd64, 8'd0);
      alloc(39'h708, 39'h3000, 12'd0, 8'd5);
      for (int c = 0; c < 10; c++) begin
         check("degen_v_o", v_o, 1'b0);
         tick();
      end
      taken.delete();
      alloc(39'h710, {V{1'b1}} - 39'd7, 12'd16, 8'd1);
      check("lat_t1", v_o, 1'b0);
      tick();
      check("lat_t2", v_o, 1'b1);
      check("wrap_vaddr", pf_vaddr_o, 64'h0);
      drain(10);

      // Random phase over four PCs, so an allocation is always acceptable.
      do_flush();
      for (int c = 0; c < 800; c++) begin
         int r;
         v_i = ($urandom_range(0, 3) == 0);
         pc_i = 39'h500 + 39'($urandom_range(0, 3) * 8);
         eff_addr_i = V'({$urandom, $urandom});
         r = $urandom_range(0, 5);
         case (r)
            0: stride_i = '0;
            1: stride_i = SW'($urandom_range(0, 64)) - SW'(32);
            2: stride_i = 12'd64;
            3: stride_i = 12'hFC0;
            4: stride_i = SW'($urandom);
            default: stride_i = 12'd8;
         endcase
         loop_counter_i = LR'($urandom_range(0, 15));
         flush_i = ($urandom_range(0, 99) == 0);
         yumi_i = v_o && ($urandom_range(0, 1) == 1);
         tick();
      end
      drain(300);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
